// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: default width, NOP encoding and the queue entry layout.
package if_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Circular instruction queue: up to FETCH_WIDTH pushes per cycle, pop of all presented
// head entries, flush-then-push, and an explicit occupancy count.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1),
  localparam int unsigned PW = $clog2(QUEUE_DEPTH),
  localparam int unsigned NW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         pop_i,
  input  logic [NW-1:0]                push_cnt_i,
  input  logic [FETCH_WIDTH*XLEN-1:0]  push_instr_i,
  input  logic [FETCH_WIDTH*XLEN-1:0]  push_pc_i,
  output logic [CW-1:0]                count_o,
  output logic [FETCH_WIDTH-1:0]       head_valid_o,
  output logic [FETCH_WIDTH*XLEN-1:0]  head_instr_o,
  output logic [FETCH_WIDTH*XLEN-1:0]  head_pc_o
);

  logic [XLEN-1:0] instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem    [QUEUE_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    if (pop_i && !flush_i) begin
      pop_cnt = (count_q >= CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : count_q;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
    // A flush abandons everything between the pointers; new pushes still land at wr_ptr_q.
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CW'(push_cnt_i);
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
      count_d  = count_q + CW'(push_cnt_i) - pop_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (NW'(i) < push_cnt_i) begin
        instr_mem[wr_ptr_q + PW'(i)] <= push_instr_i[i*XLEN +: XLEN];
        pc_mem[wr_ptr_q + PW'(i)]    <= push_pc_i[i*XLEN +: XLEN];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_head
      logic [PW-1:0] idx;
      assign idx              = rd_ptr_q + PW'(gi);
      assign head_valid_o[gi] = (count_q > CW'(gi));
      assign head_instr_o[gi*XLEN +: XLEN] = head_valid_o[gi] ? instr_mem[idx] : XLEN'(NOP_INSTR);
      assign head_pc_o[gi*XLEN +: XLEN]    = head_valid_o[gi] ? pc_mem[idx] : '0;
    end
  endgenerate

  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch front end: PC register, block alignment of the fetch address,
// fetch/pop/flush control, and the instruction queue feeding decode.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1),
  localparam int unsigned NW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [XLEN-1:0]              PC_init,
  input  logic                         REDIRECT,
  input  logic [XLEN-1:0]              REDIRECT_PC,
  input  logic                         FREEZE,
  output logic [XLEN-1:0]              IM_ADDR,
  input  logic [FETCH_WIDTH*XLEN-1:0]  IM_RDATA,
  input  logic                         ID_READY,
  output logic [FETCH_WIDTH-1:0]       ID_VALID,
  output logic [FETCH_WIDTH*XLEN-1:0]  ID_INSTR,
  output logic [FETCH_WIDTH*XLEN-1:0]  ID_PC,
  output logic [CW-1:0]                QUEUE_COUNT
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] block_base;
  logic [XLEN-1:0] offset;
  logic [CW-1:0]   count;
  logic            fetch_fire;
  logic            pop;
  logic [NW-1:0]   push_cnt;
  logic [FETCH_WIDTH*XLEN-1:0] push_instr;
  logic [FETCH_WIDTH*XLEN-1:0] push_pc;

  assign fetch_addr = REDIRECT ? REDIRECT_PC : pc_q;
  assign block_base = fetch_addr & ~XLEN'(4 * FETCH_WIDTH - 1);
  assign offset     = (fetch_addr - block_base) >> 2;
  assign IM_ADDR    = block_base;

  // Space is judged on the start-of-cycle count, so a same-cycle pop never enables a fetch.
  assign fetch_fire = !FREEZE && (count <= CW'(QUEUE_DEPTH - FETCH_WIDTH));
  assign pop        = ID_READY && !FREEZE && !REDIRECT;
  assign push_cnt   = fetch_fire ? (NW'(FETCH_WIDTH) - NW'(offset)) : '0;

  // Slots before the target offset are dropped; the rest are compacted down to slot 0.
  always_comb begin
    push_instr = '0;
    push_pc    = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (XLEN'(k) >= offset) begin
        push_instr[(k - int'(offset))*XLEN +: XLEN] = IM_RDATA[k*XLEN +: XLEN];
        push_pc[(k - int'(offset))*XLEN +: XLEN]    = block_base + XLEN'(4 * k);
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (fetch_fire) begin
      pc_d = block_base + XLEN'(4 * FETCH_WIDTH);
    end else if (REDIRECT) begin
      pc_d = REDIRECT_PC;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q <= PC_init;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_fetch_queue #(
    .XLEN        (XLEN),
    .FETCH_WIDTH (FETCH_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (CLK),
    .rst          (RESET),
    .flush_i      (REDIRECT),
    .pop_i        (pop),
    .push_cnt_i   (push_cnt),
    .push_instr_i (push_instr),
    .push_pc_i    (push_pc),
    .count_o      (count),
    .head_valid_o (ID_VALID),
    .head_instr_o (ID_INSTR),
    .head_pc_o    (ID_PC)
  );

  assign QUEUE_COUNT = count;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int XL = 32;
  localparam int FW = 2;
  localparam int QD = 8;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [XL-1:0]   PC_init;
  logic            REDIRECT;
  logic [XL-1:0]   REDIRECT_PC;
  logic            FREEZE;
  logic [XL-1:0]   IM_ADDR;
  logic [FW*XL-1:0] IM_RDATA;
  logic            ID_READY;
  logic [FW-1:0]   ID_VALID;
  logic [FW*XL-1:0] ID_INSTR;
  logic [FW*XL-1:0] ID_PC;
  logic [3:0]      QUEUE_COUNT;

  int checks = 0;
  int failures = 0;

  if_fetch_buffer #(.XLEN(XL), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD)) dut (
    .CLK(CLK), .RESET(RESET), .PC_init(PC_init), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .FREEZE(FREEZE), .IM_ADDR(IM_ADDR),
    .IM_RDATA(IM_RDATA), .ID_READY(ID_READY), .ID_VALID(ID_VALID),
    .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .QUEUE_COUNT(QUEUE_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_9E17 ^ (a << 3);
  endfunction

  genvar gk;
  generate
    for (gk = 0; gk < FW; gk++) begin : g_mem
      assign IM_RDATA[gk*XL +: XL] = mem_word(IM_ADDR + 32'(4 * gk));
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {instr, pc} plus the architectural PC.
  fetch_entry_t mq[$];
  logic [31:0]  pc_m;
  logic [31:0]  ma, mb;
  int           mo, mfree;
  bit           mfire;
  fetch_entry_t ent;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mq.delete();
      pc_m = PC_init;
    end else begin
      ma    = REDIRECT ? REDIRECT_PC : pc_m;
      mb    = ma & ~32'(4 * FW - 1);
      mo    = int'((ma - mb) / 4);
      mfree = QD - mq.size();
      mfire = !FREEZE && (mfree >= FW);
      if (REDIRECT) begin
        mq.delete();
      end else if (ID_READY && !FREEZE) begin
        for (int p = 0; p < FW; p++) begin
          if (mq.size() > 0) void'(mq.pop_front());
        end
      end
      if (mfire) begin
        for (int k = mo; k < FW; k++) begin
          ent.pc    = mb + 32'(4 * k);
          ent.instr = mem_word(ent.pc);
          mq.push_back(ent);
        end
        pc_m = mb + 32'(4 * FW);
      end else if (REDIRECT) begin
        pc_m = REDIRECT_PC;
      end
    end
  end

  logic [FW-1:0]    exp_valid;
  logic [FW*XL-1:0] exp_instr, exp_pc;
  logic [31:0]      exp_addr;

  always @(negedge CLK) begin
    exp_valid = '0;
    exp_instr = '0;
    exp_pc    = '0;
    for (int k = 0; k < FW; k++) begin
      if (k < mq.size()) begin
        exp_valid[k]          = 1'b1;
        exp_instr[k*XL +: XL] = mq[k].instr;
        exp_pc[k*XL +: XL]    = mq[k].pc;
      end
    end
    exp_addr = (REDIRECT ? REDIRECT_PC : pc_m) & ~32'(4 * FW - 1);
    check("im_addr", 64'(IM_ADDR), 64'(exp_addr));
    check("id_valid", 64'(ID_VALID), 64'(exp_valid));
    check("id_instr", 64'(ID_INSTR), 64'(exp_instr));
    check("id_pc", 64'(ID_PC), 64'(exp_pc));
    check("queue_count", 64'(QUEUE_COUNT), 64'(mq.size()));
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; PC_init = 32'h100; REDIRECT = 1'b0; REDIRECT_PC = '0;
    FREEZE = 1'b0; ID_READY = 1'b0;
    repeat (3) cyc();
    at_neg();
    check("rst_count", 64'(QUEUE_COUNT), 64'd0);
    check("rst_valid_pc", {ID_PC[31:0], 30'd0, ID_VALID}, 64'd0);

    // Reset release and first two fetch blocks
    cyc(); RESET = 1'b0; ID_READY = 1'b1;
    at_neg(); check("first_addr", 64'(IM_ADDR), 64'h100);
    cyc();
    at_neg();
    check("first_pcs", ID_PC, 64'h0000_0104_0000_0100);
    check("second_addr", 64'(IM_ADDR), 64'h108);

    // Backpressure fills to 8, single pop allows one more fetch
    cyc(); ID_READY = 1'b0;
    repeat (4) cyc();
    at_neg();
    check("bp_full", 64'(QUEUE_COUNT), 64'd8);
    check("bp_addr_hold", 64'(IM_ADDR), 64'h128);
    check("bp_head", ID_PC, 64'h0000_010C_0000_0108);
    cyc(); ID_READY = 1'b1;
    cyc(); ID_READY = 1'b0;
    at_neg();
    check("bp_popped", 64'(QUEUE_COUNT), 64'd6);
    check("bp_no_fetch", 64'(IM_ADDR), 64'h128);
    cyc();
    at_neg();
    check("bp_refill", 64'(QUEUE_COUNT), 64'd8);
    check("bp_next_addr", 64'(IM_ADDR), 64'h130);

    // Aligned redirect with 6 queued, then misaligned redirect
    cyc(); ID_READY = 1'b1;
    cyc(); REDIRECT = 1'b1; REDIRECT_PC = 32'h400;
    at_neg(); check("rd_count_before", 64'(QUEUE_COUNT), 64'd6);
    check("rd_addr", 64'(IM_ADDR), 64'h400);
    cyc(); REDIRECT = 1'b1; REDIRECT_PC = 32'h204;
    at_neg();
    check("rd_count", 64'(QUEUE_COUNT), 64'd2);
    check("rd_pcs", ID_PC, 64'h0000_0404_0000_0400);
    check("mis_addr", 64'(IM_ADDR), 64'h200);
    cyc(); REDIRECT = 1'b0;
    at_neg();
    check("mis_valid", 64'(ID_VALID), 64'b01);
    check("mis_pc", ID_PC, 64'h0000_0000_0000_0204);
    check("mis_next_addr", 64'(IM_ADDR), 64'h208);

    // Freeze for three cycles with a redirect in the middle
    cyc(); FREEZE = 1'b1;
    cyc(); REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
    cyc(); REDIRECT = 1'b0;
    at_neg();
    check("frz_flushed", 64'(QUEUE_COUNT), 64'd0);
    cyc(); FREEZE = 1'b0;
    at_neg();
    check("frz_addr", 64'(IM_ADDR), 64'h300);
    check("frz_count", 64'(QUEUE_COUNT), 64'd0);

    // Address wrap from the top block
    cyc(); RESET = 1'b1; PC_init = 32'hFFFF_FFF8; ID_READY = 1'b1;
    cyc(); RESET = 1'b0;
    at_neg(); check("wrap_addr0", 64'(IM_ADDR), 64'hFFFF_FFF8);
    cyc();
    at_neg();
    check("wrap_addr1", 64'(IM_ADDR), 64'h0);
    check("wrap_pcs", ID_PC, 64'hFFFF_FFFC_FFFF_FFF8);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      cyc();
      RESET       = ($urandom_range(0, 99) < 1);
      PC_init     = $urandom & 32'hFFFF_FFFC;
      ID_READY    = ($urandom_range(0, 99) < 65);
      FREEZE      = ($urandom_range(0, 99) < 10);
      REDIRECT    = ($urandom_range(0, 99) < 8);
      REDIRECT_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                : ($urandom & 32'hFFFF_FFFC);
      $display("cyc %0d rst=%0b rdy=%0b frz=%0b redir=%0b tgt=%h addr=%h cnt=%0d",
               c, RESET, ID_READY, FREEZE, REDIRECT, REDIRECT_PC, IM_ADDR, QUEUE_COUNT);
    end
    cyc(); RESET = 1'b0; REDIRECT = 1'b0; FREEZE = 1'b0;
    repeat (3) cyc();
    at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
